// File: rtl/enigma_pkg.sv
// Shared types, wiring tables, notch letters and mod-26 helpers for the enigma cipher core.
package enigma_pkg;

  typedef logic [4:0] letter_t;  // 1=A .. 26=Z, 0 = none
  typedef logic [4:0] idx_t;     // 0..25

  typedef enum logic [1:0] {ROT_I, ROT_II, ROT_III, ROT_REF} rotor_sel_t;
  typedef enum logic [1:0] {IDLE, STEP, ENC, DONE} state_t;

  localparam idx_t WIRE_I_FWD [26] = '{
    5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
    5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
  localparam idx_t WIRE_I_INV [26] = '{
    5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
    5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
  localparam idx_t WIRE_II_FWD [26] = '{
    5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
    5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
  localparam idx_t WIRE_II_INV [26] = '{
    5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
  localparam idx_t WIRE_III_FWD [26] = '{
    5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
    5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
  localparam idx_t WIRE_III_INV [26] = '{
    5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
    5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
  localparam idx_t WIRE_REF_B [26] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

  localparam letter_t NOTCH_I   = 5'd17;  // Q
  localparam letter_t NOTCH_II  = 5'd5;   // E
  localparam letter_t NOTCH_III = 5'd22;  // V

  function automatic idx_t add26(input idx_t a, input idx_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic idx_t sub26(input idx_t a, input idx_t b);
    logic [5:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + 6'd26 - {1'b0, b};
    return d[4:0];
  endfunction

  function automatic logic letter_ok(input letter_t l);
    return (l != 5'd0) && (l <= 5'd26);
  endfunction

  function automatic letter_t letter_inc(input letter_t l);
    return (l == 5'd26) ? 5'd1 : l + 5'd1;
  endfunction

endpackage

// File: rtl/enigma_rotor_stage.sv
// One combinational substitution through a rotor (either direction) or the reflector.
module enigma_rotor_stage
  import enigma_pkg::*;
(
  input  logic [4:0] i_x,
  input  logic [4:0] i_window,
  input  logic [4:0] i_ring,
  input  logic [1:0] i_sel,
  input  logic       i_inv,
  output logic [4:0] o_y
);

  rotor_sel_t w_sel;
  idx_t       w_s;
  idx_t       w_a;
  idx_t       w_w;

  assign w_sel = rotor_sel_t'(i_sel);

  always_comb begin
    // The reflector does not rotate, so its offset is fixed at zero.
    w_s = (w_sel == ROT_REF) ? '0 : sub26(i_window - 5'd1, i_ring - 5'd1);
    w_a = add26(i_x, w_s);
    w_w = '0;
    case (w_sel)
      ROT_I:   w_w = i_inv ? WIRE_I_INV[w_a]   : WIRE_I_FWD[w_a];
      ROT_II:  w_w = i_inv ? WIRE_II_INV[w_a]  : WIRE_II_FWD[w_a];
      ROT_III: w_w = i_inv ? WIRE_III_INV[w_a] : WIRE_III_FWD[w_a];
      default: w_w = WIRE_REF_B[w_a];
    endcase
    o_y = sub26(w_w, w_s);
  end

endmodule

// File: rtl/enigma_core.sv
// Enigma I cipher engine (rotors I-II-III, reflector B): one keypress, step, 7-stage encode.
module enigma_core
  import enigma_pkg::*;
#(
  parameter int unsigned RING_L = 1,
  parameter int unsigned RING_M = 1,
  parameter int unsigned RING_R = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       key_valid_in,
  input  logic [4:0] key_letter_in,
  input  logic       pos_load_in,
  input  logic [4:0] pos_l_in,
  input  logic [4:0] pos_m_in,
  input  logic [4:0] pos_r_in,
  output logic       busy_out,
  output logic       code_valid_out,
  output logic [4:0] orig_letter_out,
  output logic [4:0] code_letter_out,
  output logic [4:0] pos_l_out,
  output logic [4:0] pos_m_out,
  output logic [4:0] pos_r_out
);

  localparam letter_t RING_L_L = letter_t'(RING_L);
  localparam letter_t RING_M_L = letter_t'(RING_M);
  localparam letter_t RING_R_L = letter_t'(RING_R);

  state_t     r_state;
  logic [2:0] r_stage;
  idx_t       r_acc;
  letter_t    r_key;
  letter_t    r_pos_l, r_pos_m, r_pos_r;
  logic       r_busy, r_valid;
  letter_t    r_orig, r_code;

  letter_t    w_window, w_ring;
  rotor_sel_t w_sel;
  logic       w_inv;
  idx_t       w_y;

  // Stage order: R, M, L forward, reflector, then L, M, R inverse.
  always_comb begin
    w_window = r_pos_r;
    w_ring   = RING_R_L;
    w_sel    = ROT_III;
    w_inv    = 1'b0;
    case (r_stage)
      3'd0: begin w_window = r_pos_r; w_ring = RING_R_L; w_sel = ROT_III; w_inv = 1'b0; end
      3'd1: begin w_window = r_pos_m; w_ring = RING_M_L; w_sel = ROT_II;  w_inv = 1'b0; end
      3'd2: begin w_window = r_pos_l; w_ring = RING_L_L; w_sel = ROT_I;   w_inv = 1'b0; end
      3'd3: begin w_window = r_pos_l; w_ring = RING_L_L; w_sel = ROT_REF; w_inv = 1'b0; end
      3'd4: begin w_window = r_pos_l; w_ring = RING_L_L; w_sel = ROT_I;   w_inv = 1'b1; end
      3'd5: begin w_window = r_pos_m; w_ring = RING_M_L; w_sel = ROT_II;  w_inv = 1'b1; end
      default: begin w_window = r_pos_r; w_ring = RING_R_L; w_sel = ROT_III; w_inv = 1'b1; end
    endcase
  end

  enigma_rotor_stage u_stage (
    .i_x      (r_acc),
    .i_window (w_window),
    .i_ring   (w_ring),
    .i_sel    (w_sel),
    .i_inv    (w_inv),
    .o_y      (w_y)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_acc   <= '0;
      r_key   <= '0;
      r_pos_l <= 5'd1;
      r_pos_m <= 5'd1;
      r_pos_r <= 5'd1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_orig  <= '0;
      r_code  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pos_load_in) begin
            if (letter_ok(pos_l_in) && letter_ok(pos_m_in) && letter_ok(pos_r_in)) begin
              r_pos_l <= pos_l_in;
              r_pos_m <= pos_m_in;
              r_pos_r <= pos_r_in;
            end
          end else if (key_valid_in && letter_ok(key_letter_in)) begin
            r_key   <= key_letter_in;
            r_busy  <= 1'b1;
            r_state <= STEP;
          end
        end
        STEP: begin
          // Double step: notch tests use the positions before this edge.
          r_pos_r <= letter_inc(r_pos_r);
          if (r_pos_r == NOTCH_III || r_pos_m == NOTCH_II) r_pos_m <= letter_inc(r_pos_m);
          if (r_pos_m == NOTCH_II) r_pos_l <= letter_inc(r_pos_l);
          r_acc   <= r_key - 5'd1;
          r_stage <= '0;
          r_state <= ENC;
        end
        ENC: begin
          r_acc   <= w_y;
          r_stage <= r_stage + 3'd1;
          if (r_stage == 3'd6) begin
            r_code  <= w_y + 5'd1;
            r_orig  <= r_key;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_out        = r_busy;
  assign code_valid_out  = r_valid;
  assign orig_letter_out = r_orig;
  assign code_letter_out = r_code;
  assign pos_l_out       = r_pos_l;
  assign pos_m_out       = r_pos_m;
  assign pos_r_out       = r_pos_r;

  logic w_unused;
  assign w_unused = ^{NOTCH_I, RING_L_L[0]};

endmodule

// File: tb/tb_enigma_core.sv
// Directed self-checking bench for enigma_core with hand-computed cipher and rotor positions.
module tb_enigma_core;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       key_valid_in = 1'b0;
  logic [4:0] key_letter_in = '0;
  logic       pos_load_in = 1'b0;
  logic [4:0] pos_l_in = '0, pos_m_in = '0, pos_r_in = '0;
  logic       busy_out, code_valid_out;
  logic [4:0] orig_letter_out, code_letter_out, pos_l_out, pos_m_out, pos_r_out;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int snap;
  int lat;

  enigma_core #(.RING_L(1), .RING_M(1), .RING_R(1)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .key_valid_in    (key_valid_in),
    .key_letter_in   (key_letter_in),
    .pos_load_in     (pos_load_in),
    .pos_l_in        (pos_l_in),
    .pos_m_in        (pos_m_in),
    .pos_r_in        (pos_r_in),
    .busy_out        (busy_out),
    .code_valid_out  (code_valid_out),
    .orig_letter_out (orig_letter_out),
    .code_letter_out (code_letter_out),
    .pos_l_out       (pos_l_out),
    .pos_m_out       (pos_m_out),
    .pos_r_out       (pos_r_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (code_valid_out === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int l, input int m, input int r);
    check({tag, ".l"}, 32'(pos_l_out), 32'(l));
    check({tag, ".m"}, 32'(pos_m_out), 32'(m));
    check({tag, ".r"}, 32'(pos_r_out), 32'(r));
  endtask

  task automatic load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    @(negedge clk_in);
    pos_load_in = 1'b1; pos_l_in = l; pos_m_in = m; pos_r_in = r;
    @(posedge clk_in); #1;
    pos_load_in = 1'b0;
  endtask

  // Presses a key, returns cycles from accept edge to code_valid, then waits for idle.
  task automatic press(input logic [4:0] k, output int cyc);
    @(negedge clk_in);
    key_valid_in = 1'b1; key_letter_in = k;
    @(posedge clk_in); #1;
    key_valid_in = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk_in); #1;
      cyc++;
      if (code_valid_out === 1'b1) break;
    end
    @(posedge clk_in); #1;
  endtask

  task automatic key_check(input string tag, input logic [4:0] k, input int code);
    press(k, lat);
    check({tag, ".lat"}, 32'(lat), 32'd8);
    check({tag, ".code"}, 32'(code_letter_out), 32'(code));
    check({tag, ".orig"}, 32'(orig_letter_out), 32'(k));
    check({tag, ".busy"}, 32'(busy_out), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("rst.code", 32'(code_letter_out), 32'd0);
    check("rst.orig", 32'(orig_letter_out), 32'd0);
    check("rst.busy", 32'(busy_out), 32'd0);
    check("rst.valid", 32'(code_valid_out), 32'd0);
    check_pos("rst.pos", 1, 1, 1);
    @(negedge clk_in) rst_in = 1'b1;

    // AAAAA -> BDZGO
    key_check("s1.k1", 5'd1, 2);
    key_check("s1.k2", 5'd1, 4);
    key_check("s1.k3", 5'd1, 26);
    key_check("s1.k4", 5'd1, 7);
    key_check("s1.k5", 5'd1, 15);
    check_pos("s1.pos", 1, 1, 6);
    check("s1.pulses", 32'(pulses), 32'd5);

    // Out-of-range load and key are ignored.
    load(5'd0, 5'd3, 5'd3);
    check_pos("badload", 1, 1, 6);
    @(negedge clk_in);
    key_valid_in = 1'b1; key_letter_in = 5'd27;
    @(posedge clk_in); #1;
    key_valid_in = 1'b0;
    check("badkey.busy", 32'(busy_out), 32'd0);

    // Double step from ADU.
    load(5'd1, 5'd4, 5'd21);
    check_pos("s2.load", 1, 4, 21);
    press(5'd1, lat); check_pos("s2.p1", 1, 4, 22);
    press(5'd1, lat); check_pos("s2.p2", 1, 5, 23);
    press(5'd1, lat); check_pos("s2.p3", 2, 6, 24);

    load(5'd26, 5'd5, 5'd1);
    press(5'd3, lat);
    check_pos("s3", 1, 6, 2);

    // Reciprocity: at AAA, B encodes to A.
    load(5'd1, 5'd1, 5'd1);
    key_check("s4", 5'd2, 1);

    // Key and load pulsed while busy are dropped.
    load(5'd1, 5'd1, 5'd1);
    snap = pulses;
    @(negedge clk_in);
    key_valid_in = 1'b1; key_letter_in = 5'd1;
    @(posedge clk_in); #1;
    key_valid_in = 1'b0;
    check("s5.busy", 32'(busy_out), 32'd1);
    repeat (2) @(posedge clk_in);
    #1;
    key_valid_in = 1'b1; key_letter_in = 5'd5;
    pos_load_in = 1'b1; pos_l_in = 5'd10; pos_m_in = 5'd10; pos_r_in = 5'd10;
    @(posedge clk_in); #1;
    key_valid_in = 1'b0; pos_load_in = 1'b0;
    repeat (12) @(posedge clk_in);
    #1;
    check("s5.pulses", 32'(pulses - snap), 32'd1);
    check("s5.code", 32'(code_letter_out), 32'd2);
    check_pos("s5.pos", 1, 1, 2);
    check("s5.idle", 32'(busy_out), 32'd0);

    // Asynchronous reset mid-encode.
    snap = pulses;
    @(negedge clk_in);
    key_valid_in = 1'b1; key_letter_in = 5'd1;
    @(posedge clk_in); #1;
    key_valid_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    check("s6.code", 32'(code_letter_out), 32'd0);
    check("s6.orig", 32'(orig_letter_out), 32'd0);
    check("s6.busy", 32'(busy_out), 32'd0);
    check_pos("s6.pos", 1, 1, 1);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b1;
    repeat (12) @(posedge clk_in);
    #1;
    check("s6.nopulse", 32'(pulses - snap), 32'd0);
    key_check("s6.k", 5'd1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
